// File: rtl/key_cmd_ctrl_pkg.sv
// Shared definitions for the keyboard-to-command controller and its consumers.
// Holds key channel assignments, the per-key FSM state encoding and the
// command bit positions the window and environment controllers slice out
// of cmd_pulse.
package key_cmd_ctrl_pkg;

    // Default number of key channels coming from the PS/2 parser
    localparam int NUM_KEYS_DEF = 16;

    // Key channel assignments (index i drives cmd_pulse bit i)
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_E     = 4;
    localparam int KEY_R     = 5;
    localparam int KEY_SPACE = 8;
    localparam int KEY_IN    = 9;
    localparam int KEY_OUT   = 10;

    // Window controller command bits: the arrow keys pan the window
    localparam int WIN_UP_BIT    = KEY_UP;
    localparam int WIN_DOWN_BIT  = KEY_DOWN;
    localparam int WIN_LEFT_BIT  = KEY_LEFT;
    localparam int WIN_RIGHT_BIT = KEY_RIGHT;

    // Environment controller command bits: E and R edit the environment
    localparam int ENVO_E_BIT = KEY_E;
    localparam int ENVO_R_BIT = KEY_R;

    // Per-key press/repeat FSM states
    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_DELAY  = 2'd1,
        KS_REPEAT = 2'd2,
        KS_HELD   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_cmd_ctrl_key_repeat.sv
// Single-key press detector with optional auto-repeat.
// A rising edge on the key emits one pulse. With repeat enabled the key then
// waits REPEAT_DELAY cycles (measured pulse to pulse) before emitting a
// pulse every REPEAT_RATE cycles for as long as it stays held.
module key_repeat
    import key_cmd_ctrl_pkg::*;
#(
    parameter int CW           = 24,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 2_500_000,
    parameter bit EN_REPEAT    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic key_prev,
    output logic pulse
);

    // Counter load values: the counter runs down to zero inclusive, so a
    // load of N-1 yields a pulse spacing of exactly N cycles.
    localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // Next-state logic: release always wins and returns to idle silently;
    // the counter is only decremented while nonzero and reloads at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            KS_IDLE: begin
                if (key && !key_prev) begin
                    pulse_d = 1'b1;
                    if (EN_REPEAT) begin
                        state_d = KS_DELAY;
                        cnt_d   = DELAY_LOAD;
                    end else begin
                        state_d = KS_HELD;
                    end
                end
            end
            KS_DELAY: begin
                if (!key) begin
                    state_d = KS_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    pulse_d = 1'b1;
                    cnt_d   = RATE_LOAD;
                    state_d = KS_REPEAT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            KS_REPEAT: begin
                if (!key) begin
                    state_d = KS_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    pulse_d = 1'b1;
                    cnt_d   = RATE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            KS_HELD: begin
                if (!key) begin
                    state_d = KS_IDLE;
                end
            end
            default: begin
                state_d = KS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, counter and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KS_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keyboard-to-command controller.
// Turns held-key levels into one-cycle command pulses (one key_repeat per
// channel), toggles the run/edit mode on the mode key and maintains a
// saturating power-of-two view_width zoom register.
module key_cmd_ctrl
    import key_cmd_ctrl_pkg::*;
#(
    parameter int                  NUM_KEYS     = NUM_KEYS_DEF,
    parameter int                  CW           = 24,
    parameter int                  REPEAT_DELAY = 12_500_000,
    parameter int                  REPEAT_RATE  = 2_500_000,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK  = NUM_KEYS'(16'h00FF),
    parameter int                  MODE_IDX     = KEY_SPACE,
    parameter int                  ZIN_IDX      = KEY_IN,
    parameter int                  ZOUT_IDX     = KEY_OUT,
    parameter int                  ZW           = 8,
    parameter int                  ZOOM_MIN     = 8,
    parameter int                  ZOOM_MAX     = 128,
    parameter int                  ZOOM_INIT    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] cmd_pulse,
    output logic                mode,
    output logic [ZW-1:0]       view_width
);

    // Zoom bounds at the widened compare width and at the register width
    localparam logic [ZW:0]   ZMIN_WIDE = (ZW + 1)'(ZOOM_MIN);
    localparam logic [ZW:0]   ZMAX_WIDE = (ZW + 1)'(ZOOM_MAX);
    localparam logic [ZW-1:0] ZMIN_REG  = ZW'(ZOOM_MIN);
    localparam logic [ZW-1:0] ZMAX_REG  = ZW'(ZOOM_MAX);
    localparam logic [ZW-1:0] ZINIT_REG = ZW'(ZOOM_INIT);

    logic [NUM_KEYS-1:0] key_prev_q;
    logic [NUM_KEYS-1:0] pulse_w;
    logic                mode_q, mode_d;
    logic [ZW-1:0]       view_width_q, view_width_d;
    logic [ZW:0]         zin_wide, zout_wide;
    logic                zin_pulse, zout_pulse;

    // One press/repeat engine per key channel
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_repeat #(
            .CW           (CW),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .EN_REPEAT    (REPEAT_MASK[i])
        ) u_key_repeat (
            .clk      (clk),
            .rst      (rst),
            .key      (keys[i]),
            .key_prev (key_prev_q[i]),
            .pulse    (pulse_w[i])
        );
    end

    assign zin_pulse  = pulse_w[ZIN_IDX];
    assign zout_pulse = pulse_w[ZOUT_IDX];

    // Shifts are done one bit wider than the register so doubling the
    // largest value cannot wrap before the clamp sees it.
    assign zin_wide  = {1'b0, view_width_q} >> 1;
    assign zout_wide = {1'b0, view_width_q} << 1;

    // Mode and zoom next-state: act on last cycle's registered pulses;
    // opposing zoom pulses in the same cycle cancel.
    always_comb begin
        mode_d       = mode_q;
        view_width_d = view_width_q;
        if (pulse_w[MODE_IDX]) begin
            mode_d = ~mode_q;
        end
        if (zin_pulse && !zout_pulse) begin
            view_width_d = (zin_wide < ZMIN_WIDE) ? ZMIN_REG : zin_wide[ZW-1:0];
        end else if (zout_pulse && !zin_pulse) begin
            view_width_d = (zout_wide > ZMAX_WIDE) ? ZMAX_REG : zout_wide[ZW-1:0];
        end
    end

    // key_prev tracks keys even during reset, so a key held across reset
    // release is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        key_prev_q <= keys;
        if (rst) begin
            mode_q       <= 1'b0;
            view_width_q <= ZINIT_REG;
        end else begin
            mode_q       <= mode_d;
            view_width_q <= view_width_d;
        end
    end

    assign cmd_pulse  = pulse_w;
    assign mode       = mode_q;
    assign view_width = view_width_q;

endmodule
